// File: rtl/clk_div_multi_if.sv
// Configuration write bus for clk_div_multi: request, channel select, divide/high
// settings, plus the ready and error responses.
interface clk_div_multi_if #(
  parameter int CH_W  = 2,
  parameter int CNT_W = 16
);
  logic             CfgValid;
  logic             CfgReady;
  logic [CH_W-1:0]  CfgCh;
  logic [CNT_W-1:0] CfgDiv;
  logic [CNT_W-1:0] CfgHigh;
  logic             CfgErr;

  modport master (
    output CfgValid, CfgCh, CfgDiv, CfgHigh,
    input  CfgReady, CfgErr
  );

  modport slave (
    input  CfgValid, CfgCh, CfgDiv, CfgHigh,
    output CfgReady, CfgErr
  );
endinterface

// File: rtl/clk_div_multi.sv
// Multi-channel programmable clock divider with double-buffered period/high-time
// registers, per-channel run control and a shared SyncStart phase alignment.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | channel stopped; ClkOut/Tick low, Cnt held at 0
// ST_RUN  | channel counting 0..DivA-1, ClkOut high while Cnt < HighA
module clk_div_multi #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 16,
  parameter int CH_W   = 2
) (
  input  logic              Clk,
  input  logic              Reset,
  clk_div_multi_if.slave    cfg,
  input  logic [NUM_CH-1:0] Enable,
  input  logic              SyncStart,
  output logic [NUM_CH-1:0] ClkOut,
  output logic [NUM_CH-1:0] Tick,
  output logic [NUM_CH-1:0] Active
);

  typedef enum logic {ST_IDLE, ST_RUN} state_t;

  logic [NUM_CH-1:0]    pend;
  logic [2**CH_W-1:0]   pend_ext;
  logic [2**CH_W-1:0]   ch_ok;
  logic                 accept;
  logic                 cfg_ok;
  logic                 err_q;

  // Unimplemented channel slots read as never pending so the bus never stalls on them.
  for (genvar g = 0; g < 2**CH_W; g++) begin : g_ext
    if (g < NUM_CH) begin : g_on
      assign pend_ext[g] = pend[g];
      assign ch_ok[g]    = 1'b1;
    end else begin : g_off
      assign pend_ext[g] = 1'b0;
      assign ch_ok[g]    = 1'b0;
    end
  end

  assign cfg.CfgReady = ~pend_ext[cfg.CfgCh];
  assign accept       = cfg.CfgValid && cfg.CfgReady;
  assign cfg_ok       = ch_ok[cfg.CfgCh] && (cfg.CfgDiv >= CNT_W'(2)) &&
                        (cfg.CfgHigh != '0) && (cfg.CfgHigh < cfg.CfgDiv);

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) err_q <= 1'b0;
    else       err_q <= accept && !cfg_ok;
  end

  assign cfg.CfgErr = err_q;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    state_t           st_q, st_nxt;
    logic [CNT_W-1:0] div_a, high_a, div_s, high_s;
    logic [CNT_W-1:0] cnt_q, cnt_nxt, high_e;
    logic             pend_q, act_q, clk_q, tick_q;
    logic             clk_nxt, tick_nxt;
    logic             wr, wrap, ld;

    assign wr     = accept && cfg_ok && (cfg.CfgCh == CH_W'(i));
    assign wrap   = (st_q == ST_RUN) && (cnt_q == div_a - CNT_W'(1));
    assign ld     = pend_q && ((st_q == ST_IDLE) || wrap || SyncStart);
    // High time governing the period that begins at this edge.
    assign high_e = ld ? high_s : high_a;

    always_comb begin
      st_nxt   = st_q;
      cnt_nxt  = cnt_q;
      clk_nxt  = clk_q;
      tick_nxt = tick_q;
      if (!Enable[i] || !act_q) begin
        st_nxt   = ST_IDLE;
        cnt_nxt  = '0;
        clk_nxt  = 1'b0;
        tick_nxt = 1'b0;
      end else if (st_q == ST_IDLE) begin
        st_nxt   = ST_RUN;
        cnt_nxt  = '0;
        clk_nxt  = 1'b1;
        tick_nxt = 1'b1;
      end else if (SyncStart) begin
        cnt_nxt  = '0;
        clk_nxt  = 1'b1;
        tick_nxt = 1'b1;
      end else begin
        cnt_nxt  = wrap ? '0 : cnt_q + CNT_W'(1);
        clk_nxt  = (cnt_nxt < high_e);
        tick_nxt = (cnt_nxt == '0);
      end
    end

    always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
        st_q   <= ST_IDLE;
        cnt_q  <= '0;
        clk_q  <= 1'b0;
        tick_q <= 1'b0;
        div_a  <= '0;
        high_a <= '0;
        div_s  <= '0;
        high_s <= '0;
        pend_q <= 1'b0;
        act_q  <= 1'b0;
      end else begin
        st_q   <= st_nxt;
        cnt_q  <= cnt_nxt;
        clk_q  <= clk_nxt;
        tick_q <= tick_nxt;
        if (wr) begin
          div_s  <= cfg.CfgDiv;
          high_s <= cfg.CfgHigh;
          pend_q <= 1'b1;
        end
        if (ld) begin
          div_a  <= div_s;
          high_a <= high_s;
          pend_q <= 1'b0;
          act_q  <= 1'b1;
        end
      end
    end

    assign pend[i]   = pend_q;
    assign ClkOut[i] = clk_q;
    assign Tick[i]   = tick_q;
    assign Active[i] = act_q;
  end

endmodule
